// File: rtl/snake_tile_scheduler.sv
// -----------------------------------------------------------------------------
// snake_tile_scheduler
//
// Purpose:
//   Queues CPU tile-map updates and commits them to the tile-map RAM only
//   during vertical blanking. This keeps the renderer from ever reading a
//   half-updated frame. The block also raises a once-per-frame level
//   interrupt that paces the game loop.
//
// Ports:
//   clk         in   system clock (50 MHz)
//   reset       in   asynchronous, active-high
//   chipselect  in   Avalon slave select
//   write       in   Avalon write strobe
//   read        in   Avalon read strobe
//   address     in   [2:0] register index
//   writedata   in   [7:0] write data
//   readdata    out  [7:0] read data, registered (valid one cycle after read)
//   hcount      in   [10:0] horizontal count from the VGA counters
//   vcount      in   [9:0]  vertical count from the VGA counters
//   tile_we     out  tile RAM write enable
//   tile_addr   out  [10:0] tile RAM address, row*COLS+col
//   tile_data   out  [3:0]  tile code
//   irq         out  frame interrupt, level, held until cleared
//
// Register map:
//   0 W: col staging            R: status {3'b0, busy, overflow, range_err, full, empty}
//   1 W: row staging            R: frame counter
//   2 W: push {addr, wd[3:0]}   R: FIFO entry count
//   3 W: control: bit0 irq_en, bit1 irq clear, bit2 screen clear request,
//        bit3 clear the sticky overflow/range_err flags
//
// Build option:
//   SNAKE_CLEAR_EN - when defined, control bit2 arms a full-screen clear.
//   At the next vblank, the FSM writes code 0 to every tile before it
//   drains the queue. When undefined, bit2 is ignored.
// -----------------------------------------------------------------------------
module snake_tile_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int VACTIVE    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        tile_we,
  output logic [10:0] tile_addr,
  output logic [3:0]  tile_data,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef SNAKE_CLEAR_EN
  localparam logic [1:0]  S_CLEAR   = 2'd3;
  localparam logic [10:0] LAST_TILE = 11'(COLS * ROWS - 1);
`endif

  typedef struct packed {
    logic [10:0] addr;
    logic [3:0]  code;
  } entry_t;

  // Storage and registers
  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]  r_state;
  logic [5:0]  r_col;
  logic [4:0]  r_row;
  logic        r_irq_en;
  logic        r_irq;
  logic        r_overflow;
  logic        r_range_err;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_readdata;
  logic        r_tile_we;
  logic [10:0] r_tile_addr;
  logic [3:0]  r_tile_data;
`ifdef SNAKE_CLEAR_EN
  logic        r_clear_pending;
  logic [10:0] r_clear_cnt;
`endif

  // Decoded bus strobes and status
  logic        w_wr;
  logic        w_rd;
  logic        w_push_req;
  logic        w_ctrl_wr;
  logic        w_range_bad;
  logic        w_empty;
  logic        w_full;
  logic        w_vblank_start;
  logic        w_window_closed;
  logic        w_pop;
  logic        w_push;
  logic        w_busy;
  logic [10:0] w_push_addr;
  entry_t      w_head;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_rd_mux;
  logic        w_unused;

  assign w_wr       = chipselect & write;
  assign w_rd       = chipselect & read;
  assign w_push_req = w_wr && (address == 3'd2);
  assign w_ctrl_wr  = w_wr && (address == 3'd3);

  // Staging registers are wider than the legal range, so out-of-range
  // coordinates are representable and must be rejected here.
  assign w_range_bad = (32'(r_col) >= COLS) || (32'(r_row) >= ROWS);

  // Constant multiply folds to shift-add (row*32 + row*8 for 40 columns).
  // Legal coordinates stay below 2048, so 11 bits never overflow.
  assign w_push_addr = 11'(r_row) * 11'(COLS) + 11'(r_col);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rd_ptr];

  assign w_vblank_start  = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign w_window_closed = (vcount == 10'd0);

  // Pop only while the blanking window is still open.
  // A full FIFO still accepts a push in a cycle that also pops.
  assign w_pop  = (r_state == S_DRAIN) && !w_window_closed && !w_empty;
  assign w_push = w_push_req && !w_range_bad && (!w_full || w_pop);

`ifdef SNAKE_CLEAR_EN
  assign w_busy = (r_state == S_DRAIN) || (r_state == S_CLEAR);
`else
  assign w_busy = (r_state == S_DRAIN);
`endif

  // writedata[7:6] carry no register field.
  assign w_unused = &{1'b0, writedata[7:6]};

  // Next-state logic
  // NOTE: every signal written in always_comb gets a default on entry so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_vblank_start) begin
`ifdef SNAKE_CLEAR_EN
          if (r_clear_pending) w_state_nxt = S_CLEAR;
          else if (!w_empty)   w_state_nxt = S_DRAIN;
`else
          if (!w_empty) w_state_nxt = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        // Entries not yet popped stay queued for the next frame.
        if (w_window_closed || w_empty) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
`ifdef SNAKE_CLEAR_EN
      S_CLEAR: begin
        // The clear runs to completion even if the window closes.
        if (r_clear_cnt == LAST_TILE) w_state_nxt = w_empty ? S_DONE : S_DRAIN;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = 8'd0;
    case (address)
      3'd0:    w_rd_mux = {3'b000, w_busy, r_overflow, r_range_err, w_full, w_empty};
      3'd1:    w_rd_mux = r_frame_cnt;
      3'd2:    w_rd_mux = 8'(r_count);
      default: w_rd_mux = 8'd0;
    endcase
  end

  // FIFO storage
  // NOTE: the entry array has no reset. After reset, the pointers and the
  // count mark every slot empty, so stale contents are never read, and the
  // array can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_addr, writedata[3:0]};
  end

  // Control and datapath state
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_col       <= 6'd0;
      r_row       <= 5'd0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_overflow  <= 1'b0;
      r_range_err <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_readdata  <= 8'd0;
      r_tile_we   <= 1'b0;
      r_tile_addr <= 11'd0;
      r_tile_data <= 4'd0;
`ifdef SNAKE_CLEAR_EN
      r_clear_pending <= 1'b0;
      r_clear_cnt     <= 11'd0;
`endif
    end else begin
      r_state <= w_state_nxt;

      // Staging and control registers
      if (w_wr && (address == 3'd0)) r_col <= writedata[5:0];
      if (w_wr && (address == 3'd1)) r_row <= writedata[4:0];
      if (w_ctrl_wr)                 r_irq_en <= writedata[0];

      // Sticky error flags: the clear bit wins. A push and a clear can
      // never coincide, because they decode from different addresses.
      if (w_ctrl_wr && writedata[3]) begin
        r_overflow  <= 1'b0;
        r_range_err <= 1'b0;
      end else if (w_push_req) begin
        if (w_range_bad)          r_range_err <= 1'b1;
        else if (w_full && !w_pop) r_overflow  <= 1'b1;
      end

      // A new vblank beats a simultaneous irq clear.
      if (w_vblank_start && r_irq_en)        r_irq <= 1'b1;
      else if (w_ctrl_wr && writedata[1])    r_irq <= 1'b0;

      if (w_vblank_start) r_frame_cnt <= r_frame_cnt + 8'd1;

      // FIFO pointers
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_rd) r_readdata <= w_rd_mux;

`ifdef SNAKE_CLEAR_EN
      // A request that arrives in the same cycle as CLEAR entry is kept,
      // so it applies to the following frame.
      if ((r_state == S_IDLE) && (w_state_nxt == S_CLEAR)) r_clear_pending <= 1'b0;
      if (w_ctrl_wr && writedata[2])                       r_clear_pending <= 1'b1;

      if ((r_state == S_IDLE) && (w_state_nxt == S_CLEAR)) r_clear_cnt <= 11'd0;
      else if (r_state == S_CLEAR)                         r_clear_cnt <= r_clear_cnt + 11'd1;
`endif

      // Tile RAM write port: the popped head appears one cycle later.
      // Address and data hold their values between writes.
      if (w_pop) begin
        r_tile_we   <= 1'b1;
        r_tile_addr <= w_head.addr;
        r_tile_data <= w_head.code;
      end
`ifdef SNAKE_CLEAR_EN
      else if (r_state == S_CLEAR) begin
        r_tile_we   <= 1'b1;
        r_tile_addr <= r_clear_cnt;
        r_tile_data <= 4'd0;
      end
`endif
      else begin
        r_tile_we <= 1'b0;
      end
    end
  end

  assign readdata  = r_readdata;
  assign tile_we   = r_tile_we;
  assign tile_addr = r_tile_addr;
  assign tile_data = r_tile_data;
  assign irq       = r_irq;

endmodule

// File: tb/tb_snake_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_snake_tile_scheduler
//
// Purpose:
//   Self-checking bench for snake_tile_scheduler. Inputs change 1 ns after
//   a rising edge, and tile RAM writes are captured on falling edges. The
//   reference keeps pending updates as a queue of (row*COLS+col, code)
//   pairs. It also tracks the sticky flags and a frame tally.
//   Build with +define+SNAKE_CLEAR_EN to add the screen-clear scenario.
// -----------------------------------------------------------------------------
module tb_snake_tile_scheduler;

  localparam int FIFO_DEPTH = 16;
  localparam int COLS       = 40;
  localparam int ROWS       = 30;
  localparam int VACTIVE    = 480;
  localparam int NTILES     = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        tile_we;
  logic [10:0] tile_addr;
  logic [3:0]  tile_data;
  logic        irq;

  always #10 clk = ~clk;

  snake_tile_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH), .COLS(COLS), .ROWS(ROWS), .VACTIVE(VACTIVE)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .hcount(hcount), .vcount(vcount), .tile_we(tile_we), .tile_addr(tile_addr),
    .tile_data(tile_data), .irq(irq)
  );

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int addr; int data; } ent_t;

  wr_t  obs_q[$];
  ent_t m_q[$];
  bit   m_ovf;
  bit   m_rng;
  int   m_frames;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tile_we === 1'b1) obs_q.push_back('{int'(tile_addr), int'(tile_data), cyc});

  // ---------------- reference model ----------------
  function automatic void m_reset();
    m_q.delete();
    m_ovf = 0;
    m_rng = 0;
    m_frames = 0;
  endfunction

  function automatic void m_push(int c, int r, int d);
    if (c >= COLS || r >= ROWS)     m_rng = 1;
    else if (m_q.size() == FIFO_DEPTH) m_ovf = 1;
    else m_q.push_back('{r * COLS + c, d});
  endfunction

  function automatic logic [7:0] m_status(bit busy);
    return {3'b000, busy, m_ovf, m_rng, m_q.size() == FIFO_DEPTH, m_q.size() == 0};
  endfunction

  // ---------------- bus / video drivers ----------------
  task automatic idle_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1; read = 1; address = a;
    @(posedge clk); #1;
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic push_tile(int c, int r, int d);
    wr_reg(3'd0, 8'(c));
    wr_reg(3'd1, 8'(r));
    wr_reg(3'd2, 8'(d));
    m_push(c, r, d);
  endtask

  task automatic vblank();
    hcount = 11'd0; vcount = 10'(VACTIVE);
    @(posedge clk); #1;
    hcount = 11'd1;
    m_frames++;
  endtask

  task automatic close_window();
    vcount = 10'd0;
    @(posedge clk); #1;
    vcount = 10'd100; hcount = 11'd5;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] d;
    reset = 1;
    idle_cycles(3);
    n_checks++; if (tile_we !== 1'b0)   begin n_errors++; $display("FAIL reset_tile_we: got %b expected 0", tile_we); end
    n_checks++; if (irq !== 1'b0)       begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (readdata !== 8'h00) begin n_errors++; $display("FAIL reset_readdata: got %h expected 00", readdata); end
    n_checks++; if (tile_addr !== 11'd0) begin n_errors++; $display("FAIL reset_tile_addr: got %0d expected 0", tile_addr); end
    reset = 0;
    m_reset();
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h01) begin n_errors++; $display("FAIL reset_status: got %h expected 01", d); end
    rd_reg(3'd1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL reset_frame_cnt: got %h expected 00", d); end
    rd_reg(3'd2, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL reset_count: got %h expected 00", d); end
  endtask

  task automatic test_single_update();
    logic [7:0] d;
    obs_q.delete();
    push_tile(5, 2, 3);
    idle_cycles(20);
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL single_early_write: got %0d writes expected 0", obs_q.size()); end
    rd_reg(3'd2, d);
    n_checks++; if (d !== 8'd1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", d); end
    vblank();
    idle_cycles(6);
    close_window();
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0].addr != 85 || obs_q[0].data != 3) begin
      n_errors++;
      $display("FAIL single_write: got %0d writes (first addr %0d data %0d) expected 1 write addr 85 data 3",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].addr : -1, (obs_q.size() > 0) ? obs_q[0].data : -1);
    end
    void'(m_q.pop_front());
    rd_reg(3'd0, d);
    n_checks++; if (d !== m_status(0)) begin n_errors++; $display("FAIL single_status: got %h expected %h", d, m_status(0)); end
  endtask

  task automatic test_range_error();
    logic [7:0] d;
    push_tile(40, 3, 7);
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h05 || d !== m_status(0)) begin n_errors++; $display("FAIL range_col_status: got %h expected 05", d); end
    push_tile(0, 30, 1);
    rd_reg(3'd2, d);
    n_checks++; if (d !== 8'd0) begin n_errors++; $display("FAIL range_row_count: got %0d expected 0", d); end
    wr_reg(3'd3, 8'h08);
    m_rng = 0; m_ovf = 0;
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h01) begin n_errors++; $display("FAIL range_cleared: got %h expected 01", d); end
  endtask

  task automatic test_random_drain();
    logic [7:0] d;
    ent_t e;
    int   n_exp;
    for (int round = 0; round < 3; round++) begin
      obs_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++)
        push_tile($urandom_range(0, 44), $urandom_range(0, 31), $urandom_range(0, 15));
      n_exp = m_q.size();
      rd_reg(3'd2, d);
      n_checks++; if (int'(d) != n_exp) begin n_errors++; $display("FAIL rand_count r%0d: got %0d expected %0d", round, d, n_exp); end
      vblank();
      idle_cycles(20);
      close_window();
      n_checks++; if (obs_q.size() != n_exp) begin n_errors++; $display("FAIL rand_nwrites r%0d: got %0d expected %0d", round, obs_q.size(), n_exp); end
      for (int i = 0; i < n_exp; i++) begin
        e = m_q.pop_front();
        n_checks++;
        if (i >= obs_q.size() || obs_q[i].addr != e.addr || obs_q[i].data != e.data) begin
          n_errors++;
          $display("FAIL rand_write r%0d[%0d]: got addr %0d data %0d expected addr %0d data %0d", round, i,
                   (i < obs_q.size()) ? obs_q[i].addr : -1, (i < obs_q.size()) ? obs_q[i].data : -1, e.addr, e.data);
        end
      end
      rd_reg(3'd0, d);
      n_checks++; if (d !== m_status(0)) begin n_errors++; $display("FAIL rand_status r%0d: got %h expected %h", round, d, m_status(0)); end
      wr_reg(3'd3, 8'h08);
      m_rng = 0; m_ovf = 0;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    ent_t e;
    obs_q.delete();
    for (int k = 0; k < 17; k++) push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h0A || d !== m_status(0)) begin n_errors++; $display("FAIL ovf_status: got %h expected 0a", d); end
    rd_reg(3'd2, d);
    n_checks++; if (d !== 8'd16) begin n_errors++; $display("FAIL ovf_count: got %0d expected 16", d); end
    vblank();
    rd_reg(3'd0, d);   // sampled on the first DRAIN cycle
    n_checks++; if (d !== 8'h1A || d !== m_status(1)) begin n_errors++; $display("FAIL ovf_busy_status: got %h expected 1a", d); end
    idle_cycles(25);
    close_window();
    n_checks++; if (obs_q.size() != 16) begin n_errors++; $display("FAIL ovf_nwrites: got %0d expected 16", obs_q.size()); end
    for (int i = 0; i < 16; i++) begin
      e = m_q.pop_front();
      n_checks++;
      if (i >= obs_q.size() || obs_q[i].addr != e.addr || obs_q[i].data != e.data || obs_q[i].cyc != obs_q[0].cyc + i) begin
        n_errors++;
        $display("FAIL ovf_write[%0d]: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d", i,
                 (i < obs_q.size()) ? obs_q[i].addr : -1, (i < obs_q.size()) ? obs_q[i].data : -1,
                 (i < obs_q.size()) ? obs_q[i].cyc : -1, e.addr, e.data, (obs_q.size() > 0) ? obs_q[0].cyc + i : -1);
      end
    end
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h09 || d !== m_status(0)) begin n_errors++; $display("FAIL ovf_sticky: got %h expected 09", d); end
    wr_reg(3'd3, 8'h08);
    m_ovf = 0; m_rng = 0;
    rd_reg(3'd0, d);
    n_checks++; if (d !== 8'h01) begin n_errors++; $display("FAIL ovf_cleared: got %h expected 01", d); end
  endtask

  task automatic test_window_close();
    logic [7:0] d;
    ent_t e;
    obs_q.delete();
    for (int k = 0; k < 8; k++) push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    vblank();
    idle_cycles(3);      // three drain cycles with the window open
    close_window();
    idle_cycles(4);
    n_checks++; if (obs_q.size() != 3) begin n_errors++; $display("FAIL win_partial: got %0d writes expected 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = m_q.pop_front();
      n_checks++;
      if (i >= obs_q.size() || obs_q[i].addr != e.addr || obs_q[i].data != e.data) begin
        n_errors++; $display("FAIL win_write[%0d]: got addr %0d expected addr %0d data %0d", i, (i < obs_q.size()) ? obs_q[i].addr : -1, e.addr, e.data);
      end
    end
    rd_reg(3'd2, d);
    n_checks++; if (int'(d) != m_q.size()) begin n_errors++; $display("FAIL win_left: got %0d expected %0d", d, m_q.size()); end
    obs_q.delete();
    vblank();
    idle_cycles(15);
    close_window();
    n_checks++; if (obs_q.size() != 5) begin n_errors++; $display("FAIL win_next_frame: got %0d writes expected 5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      e = m_q.pop_front();
      n_checks++;
      if (i >= obs_q.size() || obs_q[i].addr != e.addr || obs_q[i].data != e.data) begin
        n_errors++; $display("FAIL win_next_write[%0d]: got addr %0d expected addr %0d data %0d", i, (i < obs_q.size()) ? obs_q[i].addr : -1, e.addr, e.data);
      end
    end
  endtask

  task automatic test_push_during_drain();
    ent_t e;
    obs_q.delete();
    for (int k = 0; k < 8; k++) push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    vblank();
    push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    idle_cycles(10);
    close_window();
    n_checks++; if (obs_q.size() != 10) begin n_errors++; $display("FAIL pdd_nwrites: got %0d expected 10", obs_q.size()); end
    for (int i = 0; i < 10; i++) begin
      e = m_q.pop_front();
      n_checks++;
      if (i >= obs_q.size() || obs_q[i].addr != e.addr || obs_q[i].data != e.data) begin
        n_errors++; $display("FAIL pdd_write[%0d]: got addr %0d expected addr %0d data %0d", i, (i < obs_q.size()) ? obs_q[i].addr : -1, e.addr, e.data);
      end
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
    wr_reg(3'd3, 8'h01);
    vblank();
    idle_cycles(2);
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_first: got %b expected 1", irq); end
    idle_cycles(2); vblank(); idle_cycles(3); vblank(); idle_cycles(2);
    rd_reg(3'd1, d);
    n_checks++; if (d !== 8'(m_frames)) begin n_errors++; $display("FAIL irq_frames: got %0d expected %0d", d, 8'(m_frames)); end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_held: got %b expected 1", irq); end
    wr_reg(3'd3, 8'h03);
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    // clear and vblank in the same cycle: the new frame wins
    chipselect = 1; write = 1; address = 3'd3; writedata = 8'h03;
    hcount = 11'd0; vcount = 10'(VACTIVE);
    @(posedge clk); #1;
    chipselect = 0; write = 0; hcount = 11'd1;
    m_frames++;
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_clear_vs_vblank: got %b expected 1", irq); end
    wr_reg(3'd3, 8'h02);
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_disable_clear: got %b expected 0", irq); end
    vblank(); idle_cycles(2);
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    // walk the frame counter to its wrap point
    while ((m_frames % 256) != 255) begin vblank(); idle_cycles(1); end
    rd_reg(3'd1, d);
    n_checks++; if (d !== 8'd255) begin n_errors++; $display("FAIL frame_255: got %0d expected 255", d); end
    vblank(); idle_cycles(1);
    rd_reg(3'd1, d);
    n_checks++; if (d !== 8'd0) begin n_errors++; $display("FAIL frame_wrap: got %0d expected 0", d); end
    close_window();
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] d;
    for (int k = 0; k < 6; k++) push_tile($urandom_range(0, 39), $urandom_range(0, 29), $urandom_range(0, 15));
    vblank();
    idle_cycles(2);
    n_checks++; if (tile_we !== 1'b1) begin n_errors++; $display("FAIL rmd_draining: got %b expected 1", tile_we); end
    #4 reset = 1;
    #1;
    n_checks++; if (tile_we !== 1'b0) begin n_errors++; $display("FAIL rmd_abort: got %b expected 0", tile_we); end
    @(posedge clk); #1;
    reset = 0;
    m_reset();
    vcount = 10'd100; hcount = 11'd5;
    rd_reg(3'd0, d);
    n_checks++; if (d !== m_status(0)) begin n_errors++; $display("FAIL rmd_status: got %h expected %h", d, m_status(0)); end
    rd_reg(3'd2, d);
    n_checks++; if (d !== 8'd0) begin n_errors++; $display("FAIL rmd_count: got %0d expected 0", d); end
  endtask

`ifdef SNAKE_CLEAR_EN
  task automatic test_clear();
    ent_t e;
    obs_q.delete();
    wr_reg(3'd3, 8'h04);
    push_tile(7, 1, 9);
    vblank();
    idle_cycles(NTILES + 10);
    close_window();
    n_checks++; if (obs_q.size() != NTILES + 1) begin n_errors++; $display("FAIL clr_nwrites: got %0d expected %0d", obs_q.size(), NTILES + 1); end
    for (int i = 0; i < NTILES && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].addr != i || obs_q[i].data != 0) begin
        n_errors++; $display("FAIL clr_write[%0d]: got addr %0d data %0d expected addr %0d data 0", i, obs_q[i].addr, obs_q[i].data, i);
      end
    end
    e = m_q.pop_front();
    n_checks++;
    if (obs_q.size() <= NTILES || obs_q[NTILES].addr != e.addr || obs_q[NTILES].data != e.data) begin
      n_errors++; $display("FAIL clr_queued_entry: expected addr %0d data %0d after the clear", e.addr, e.data);
    end
    wr_reg(3'd3, 8'h04);
    vblank();
    idle_cycles(50);
    n_checks++; if (tile_we !== 1'b1) begin n_errors++; $display("FAIL clr_running: got %b expected 1", tile_we); end
    #4 reset = 1;
    #1;
    n_checks++; if (tile_we !== 1'b0) begin n_errors++; $display("FAIL clr_reset_abort: got %b expected 0", tile_we); end
    @(posedge clk); #1;
    reset = 0;
    m_reset();
    vcount = 10'd100; hcount = 11'd5;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary line in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; chipselect = 0; write = 0; read = 0; address = 3'd0; writedata = 8'd0;
    hcount = 11'd5; vcount = 10'd100;
    m_reset();
    #1;
    test_reset();
    test_single_update();
    test_range_error();
    test_random_drain();
    test_overflow();
    test_window_close();
    test_push_during_drain();
    test_irq();
    test_reset_mid_drain();
`ifdef SNAKE_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_tile_scheduler.md
Name: snake_tile_scheduler

Overview:
CPU-facing controller that queues tile updates and commits them to the tile-map RAM only during vertical blanking, so the renderer never reads a half-updated frame. Sits between the Avalon slave bus and the tile-map RAM write port. Consumes hcount/vcount from the VGA counters and raises a once-per-frame interrupt that paces the game loop.

Parameters:
FIFO_DEPTH, 16, pending tile-update entries (power of 2)
COLS, 40, tile columns (640/16)
ROWS, 30, tile rows (480/16)
VACTIVE, 480, first vcount of the vertical blanking window

Ports:
clk  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register index
writedata  in  8  write data
readdata  out  8  read data, registered
hcount  in  11  from VGA counters
vcount  in  10  from VGA counters
tile_we  out  1  tile RAM write enable
tile_addr  out  11  tile RAM address, row*COLS+col
tile_data  out  4  tile code
irq  out  1  frame interrupt, level

Behaviour:
- Reset (asynchronous, active-high, clock clk): FIFO empty; state IDLE; tile_we=0, tile_addr=0, tile_data=0, readdata=0, irq=0; irq_en=0; col/row staging=0; frame_cnt=0; overflow, range_err=0.
- Register writes (chipselect&write): addr 0 col<=writedata[5:0]; addr 1 row<=writedata[4:0]; addr 2 push {row*COLS+col, writedata[3:0]}; addr 3 control: bit0 irq_en, bit1=1 clears irq (self-clearing), bit2 clear_req (optional feature only).
- Push: col>=COLS or row>=ROWS -> dropped, range_err<=1 (sticky). FIFO full -> dropped, overflow<=1 (sticky). Both sticky bits cleared by a write to addr 3 with bit3=1.
- Address arithmetic: (row<<5)+(row<<3)+col, 11 bits, no overflow for legal ranges.
- Reads (chipselect&read): readdata valid one cycle later. addr 0 status {3'b0, busy, overflow, range_err, full, empty}; addr 1 frame_cnt; addr 2 FIFO count (5 bits zero-extended); others 0.
- vblank_start = (hcount==0 && vcount==VACTIVE), a single-cycle event per frame.
- On vblank_start: frame_cnt increments (wraps 255->0); irq<=1 if irq_en; state IDLE->DRAIN if FIFO non-empty.
- DRAIN: each cycle with FIFO non-empty: pop head; next cycle tile_we=1 with that addr/data (one write per cycle, one-cycle latency). FIFO empty -> DONE. vcount==0 (window closed) -> DONE; unpopped entries remain for the next frame.
- DONE -> IDLE on the next cycle. tile_we=0 in IDLE/DONE. tile_addr/tile_data hold their last values.
- Simultaneous push and pop: both take effect, count unchanged; pushing into a full FIFO on a pop cycle is accepted.
- Push during DRAIN is legal; entry is drained in the same window if reached before vcount wraps.
- busy=1 in DRAIN (and CLEAR).
- irq stays high until cleared; vblank_start and clear in the same cycle -> irq=1.
- Reset mid-DRAIN: immediate abort; pending entries discarded.

Optional Feature:
SNAKE_CLEAR_EN: defined -> control bit2 sets clear_pending. At the next vblank_start the FSM enters CLEAR and writes tile_data=0 to addresses 0..COLS*ROWS-1 (1200 cycles, one per cycle), then enters DRAIN if FIFO non-empty, else DONE. clear_pending clears on CLEAR entry. CLEAR is not aborted by the window closing. Undefined -> bit2 ignored, no CLEAR state.

Test Plan:
- Reset, read addr 0 -> readdata=8'h01 (empty); irq=0, tile_we=0.
- Write col=5, row=2, push code 3 at vcount=100 -> no tile_we until vblank_start; then one tile_we pulse with addr 85, data 3; status empty.
- Push 17 entries with FIFO_DEPTH=16 -> overflow=1, count=16; after vblank exactly 16 consecutive tile_we cycles in push order.
- Push col=40 -> dropped, range_err=1; write addr3=8'h08 -> range_err=0.
- irq_en=1, run 3 frames without clearing -> irq high after first vblank_start, frame_cnt=3; write addr3 bit1 -> irq=0.
- SNAKE_CLEAR_EN: set bit2, push one entry -> 1200 writes of data 0 (addr 0..1199), then the queued entry; assert reset mid-CLEAR -> tile_we=0 immediately.
